// File: rtl/reg_file_pkg.sv
// Shared types and sizes for the 4x16 register file with pending-write scoreboard.
package reg_file_pkg;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned NREGS = 4;
  localparam int unsigned AW    = 2;

  typedef logic [AW-1:0] reg_addr_t;

  localparam reg_addr_t R0 = 2'd0;

endpackage

// File: rtl/reg_read_port.sv
// One read port: 4:1 register select plus pending-hit, with optional write bypass.
// Bypass of same-cycle write data is built only when REG_FILE_BYPASS_EN is defined.
module reg_read_port
  import reg_file_pkg::*;
#(
  parameter int unsigned WIDTH = reg_file_pkg::WIDTH,
  parameter int unsigned NREGS = reg_file_pkg::NREGS
) (
  input  logic [NREGS-1:0][WIDTH-1:0] regs,
  input  logic [NREGS-1:0]            pending,
  input  reg_addr_t                   raddr,
  input  logic                        wr_valid,
  input  reg_addr_t                   waddr,
  input  logic [WIDTH-1:0]            wdata,
  output logic [WIDTH-1:0]            rdata,
  output logic                        hit
);

  always_comb begin
    rdata = regs[raddr];
    hit   = (raddr != R0) & pending[raddr];
`ifdef REG_FILE_BYPASS_EN
    // In-flight write wins over the array and satisfies the pending hazard.
    if (wr_valid && (raddr == waddr)) begin
      rdata = wdata;
      hit   = 1'b0;
    end
`endif
  end

`ifndef REG_FILE_BYPASS_EN
  logic unused_bypass;
  assign unused_bypass = ^{wr_valid, waddr, wdata};
`endif

endmodule

// File: rtl/reg_file_4x16.sv
// 4-entry register file (r0 hardwired zero) with a lock/write-back pending scoreboard.
// Optional same-cycle write bypass on the read ports: REG_FILE_BYPASS_EN.
module reg_file_4x16
  import reg_file_pkg::*;
#(
  parameter int unsigned WIDTH = reg_file_pkg::WIDTH,
  parameter int unsigned NREGS = reg_file_pkg::NREGS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  reg_addr_t        waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             lock,
  input  reg_addr_t        lock_addr,
  input  reg_addr_t        raddr1,
  input  reg_addr_t        raddr2,
  output logic [WIDTH-1:0] rdata1,
  output logic [WIDTH-1:0] rdata2,
  output logic             stall,
  output logic [NREGS-1:0] pending
);

  logic [NREGS-1:0][WIDTH-1:0] regs_q, regs_d;
  logic [NREGS-1:0]            pending_q, pending_d;
  logic                        wr_valid_c;
  logic                        byp_valid_c;
  logic                        hit1_c, hit2_c;

  assign wr_valid_c  = we & (waddr != R0);
  // Bypass is suppressed while in reset so reads stay zero.
  assign byp_valid_c = wr_valid_c & rst_n;

  // Next state: write-back clears pending, then a lock sets it (lock wins on a tie).
  always_comb begin
    regs_d    = regs_q;
    pending_d = pending_q;
    if (wr_valid_c) begin
      regs_d[waddr]    = wdata;
      pending_d[waddr] = 1'b0;
    end
    if (lock && (lock_addr != R0)) begin
      pending_d[lock_addr] = 1'b1;
    end
    regs_d[R0]    = '0;
    pending_d[R0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q    <= '0;
      pending_q <= '0;
    end else begin
      regs_q    <= regs_d;
      pending_q <= pending_d;
    end
  end

  reg_read_port #(.WIDTH(WIDTH), .NREGS(NREGS)) u_rd1 (
    .regs     (regs_q),
    .pending  (pending_q),
    .raddr    (raddr1),
    .wr_valid (byp_valid_c),
    .waddr    (waddr),
    .wdata    (wdata),
    .rdata    (rdata1),
    .hit      (hit1_c)
  );

  reg_read_port #(.WIDTH(WIDTH), .NREGS(NREGS)) u_rd2 (
    .regs     (regs_q),
    .pending  (pending_q),
    .raddr    (raddr2),
    .wr_valid (byp_valid_c),
    .waddr    (waddr),
    .wdata    (wdata),
    .rdata    (rdata2),
    .hit      (hit2_c)
  );

  assign stall   = hit1_c | hit2_c;
  assign pending = pending_q;

endmodule
